// File: rtl/ddr_wpath.sv
// Write-data path of the Wishbone DDR controller: pulls burst words from a
// FWFT write FIFO and drives registered rise/fall DQ/DM/DQS values and enables.
module ddr_wpath #(
  parameter int DQ_WIDTH     = 16,
  parameter int BURST_LENGTH = 8,
  parameter int WLAT         = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  wr_start,
  output logic                                  ready,
  input  logic                                  wfifo_empty,
  input  logic [2*DQ_WIDTH+DQ_WIDTH/4-1:0]      wfifo_dout,
  output logic                                  wfifo_next,
  output logic [DQ_WIDTH-1:0]                   ddr_dq_rise,
  output logic [DQ_WIDTH-1:0]                   ddr_dq_fall,
  output logic [DQ_WIDTH/8-1:0]                 ddr_dm_rise,
  output logic [DQ_WIDTH/8-1:0]                 ddr_dm_fall,
  output logic                                  ddr_dq_oe,
  output logic [DQ_WIDTH/8-1:0]                 ddr_dqs_rise,
  output logic [DQ_WIDTH/8-1:0]                 ddr_dqs_fall,
  output logic                                  ddr_dqs_oe,
  output logic                                  underrun,
  input  logic                                  underrun_clr,
  output logic [2:0]                            dbg_state
);

  localparam int DMW = DQ_WIDTH / 8;
  localparam int WW  = 2 * DQ_WIDTH + 2 * DMW;
  localparam logic [2:0] LAT_LOAD  = (WLAT > 1) ? 3'(WLAT - 2) : 3'd0;
  localparam logic [2:0] LAST_BEAT = 3'(BURST_LENGTH / 2 - 1);

  // Each state names what the output registers will present at the next edge.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LAT  = 3'd1,
    S_PRE  = 3'd2,
    S_DATA = 3'd3,
    S_POST = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] lat_cnt, lat_cnt_nxt;
  logic [2:0] beat_cnt, beat_cnt_nxt;
  logic       beat_due;

  assign ready     = (state == S_IDLE);
  assign dbg_state = state;
  assign beat_due  = (state == S_DATA);
  // FWFT pop lands on the same edge that registers the word; suppressed by reset
  // so an aborted beat does not consume data.
  assign wfifo_next = beat_due && !wfifo_empty && !reset;

  always_comb begin
    state_nxt    = state;
    lat_cnt_nxt  = lat_cnt;
    beat_cnt_nxt = beat_cnt;
    case (state)
      S_IDLE: begin
        if (wr_start) begin
          if (WLAT == 1) begin
            state_nxt = S_PRE;
          end else begin
            state_nxt   = S_LAT;
            lat_cnt_nxt = LAT_LOAD;
          end
        end
      end
      S_LAT: begin
        if (lat_cnt == 3'd0) state_nxt = S_PRE;
        else lat_cnt_nxt = lat_cnt - 3'd1;
      end
      S_PRE: begin
        state_nxt    = S_DATA;
        beat_cnt_nxt = 3'd0;
      end
      S_DATA: begin
        if (beat_cnt == LAST_BEAT) state_nxt = S_POST;
        else beat_cnt_nxt = beat_cnt + 3'd1;
      end
      S_POST:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      lat_cnt      <= 3'd0;
      beat_cnt     <= 3'd0;
      ddr_dq_rise  <= '0;
      ddr_dq_fall  <= '0;
      ddr_dm_rise  <= '0;
      ddr_dm_fall  <= '0;
      ddr_dq_oe    <= 1'b0;
      ddr_dqs_rise <= '0;
      ddr_dqs_fall <= '0;
      ddr_dqs_oe   <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state        <= state_nxt;
      lat_cnt      <= lat_cnt_nxt;
      beat_cnt     <= beat_cnt_nxt;
      ddr_dq_rise  <= '0;
      ddr_dq_fall  <= '0;
      ddr_dm_rise  <= '0;
      ddr_dm_fall  <= '0;
      ddr_dq_oe    <= 1'b0;
      ddr_dqs_rise <= '0;
      ddr_dqs_fall <= '0;
      ddr_dqs_oe   <= 1'b0;
      case (state)
        S_PRE:  ddr_dqs_oe <= 1'b1;
        S_DATA: begin
          ddr_dq_oe    <= 1'b1;
          ddr_dqs_oe   <= 1'b1;
          ddr_dqs_rise <= '1;
          if (wfifo_empty) begin
            // Starved beat: mask every byte so the DRAM keeps its old contents.
            ddr_dm_rise <= '1;
            ddr_dm_fall <= '1;
          end else begin
            ddr_dm_rise <= wfifo_dout[WW-1 -: DMW];
            ddr_dm_fall <= wfifo_dout[WW-DMW-1 -: DMW];
            ddr_dq_rise <= wfifo_dout[2*DQ_WIDTH-1 -: DQ_WIDTH];
            ddr_dq_fall <= wfifo_dout[DQ_WIDTH-1:0];
          end
        end
        S_POST:  ddr_dqs_oe <= 1'b1;
        default: ;
      endcase
      if (beat_due && wfifo_empty) underrun <= 1'b1;
      else if (underrun_clr)       underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ddr_wpath.sv
// Bench for ddr_wpath: FWFT FIFO model, burst-level expected output sequences
// built from the protocol timing, and scenario tasks with inline comparisons.
module tb_ddr_wpath;

  localparam int W  = 36;
  localparam int VW = 43;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main instance (WLAT=1)
  logic          wr_start = 1'b0, wfifo_empty = 1'b1, underrun_clr = 1'b0;
  logic [W-1:0]  wfifo_dout = '0;
  logic          ready, wfifo_next, ddr_dq_oe, ddr_dqs_oe, underrun;
  logic [15:0]   ddr_dq_rise, ddr_dq_fall;
  logic [1:0]    ddr_dm_rise, ddr_dm_fall, ddr_dqs_rise, ddr_dqs_fall;
  logic [2:0]    dbg_state;
  logic [VW-1:0] v_main;

  // latency sweep instances (WLAT=3, WLAT=7) share one always-full source
  logic          sw_start = 1'b0;
  logic [W-1:0]  sw_dout = 36'h5_1357_9BDF;
  logic          rdy3, nxt3, dqoe3, dqsoe3, und3, rdy7, nxt7, dqoe7, dqsoe7, und7;
  logic [15:0]   dqr3, dqf3, dqr7, dqf7;
  logic [1:0]    dmr3, dmf3, dsr3, dsf3, dmr7, dmf7, dsr7, dsf7;
  logic [2:0]    dbg3, dbg7;
  logic [VW-1:0] v3, v7;

  ddr_wpath #(.DQ_WIDTH(16), .BURST_LENGTH(8), .WLAT(1)) dut (
    .clk(clk), .reset(reset), .wr_start(wr_start), .ready(ready),
    .wfifo_empty(wfifo_empty), .wfifo_dout(wfifo_dout), .wfifo_next(wfifo_next),
    .ddr_dq_rise(ddr_dq_rise), .ddr_dq_fall(ddr_dq_fall),
    .ddr_dm_rise(ddr_dm_rise), .ddr_dm_fall(ddr_dm_fall), .ddr_dq_oe(ddr_dq_oe),
    .ddr_dqs_rise(ddr_dqs_rise), .ddr_dqs_fall(ddr_dqs_fall), .ddr_dqs_oe(ddr_dqs_oe),
    .underrun(underrun), .underrun_clr(underrun_clr), .dbg_state(dbg_state));

  ddr_wpath #(.DQ_WIDTH(16), .BURST_LENGTH(8), .WLAT(3)) dut3 (
    .clk(clk), .reset(reset), .wr_start(sw_start), .ready(rdy3),
    .wfifo_empty(1'b0), .wfifo_dout(sw_dout), .wfifo_next(nxt3),
    .ddr_dq_rise(dqr3), .ddr_dq_fall(dqf3), .ddr_dm_rise(dmr3), .ddr_dm_fall(dmf3),
    .ddr_dq_oe(dqoe3), .ddr_dqs_rise(dsr3), .ddr_dqs_fall(dsf3), .ddr_dqs_oe(dqsoe3),
    .underrun(und3), .underrun_clr(1'b0), .dbg_state(dbg3));

  ddr_wpath #(.DQ_WIDTH(16), .BURST_LENGTH(8), .WLAT(7)) dut7 (
    .clk(clk), .reset(reset), .wr_start(sw_start), .ready(rdy7),
    .wfifo_empty(1'b0), .wfifo_dout(sw_dout), .wfifo_next(nxt7),
    .ddr_dq_rise(dqr7), .ddr_dq_fall(dqf7), .ddr_dm_rise(dmr7), .ddr_dm_fall(dmf7),
    .ddr_dq_oe(dqoe7), .ddr_dqs_rise(dsr7), .ddr_dqs_fall(dsf7), .ddr_dqs_oe(dqsoe7),
    .underrun(und7), .underrun_clr(1'b0), .dbg_state(dbg7));

  // observation vector: {ready, dq_oe, dqs_oe, dqs_rise, dqs_fall, dm_rise, dm_fall, dq_rise, dq_fall}
  assign v_main = {ready, ddr_dq_oe, ddr_dqs_oe, ddr_dqs_rise, ddr_dqs_fall,
                   ddr_dm_rise, ddr_dm_fall, ddr_dq_rise, ddr_dq_fall};
  assign v3 = {rdy3, dqoe3, dqsoe3, dsr3, dsf3, dmr3, dmf3, dqr3, dqf3};
  assign v7 = {rdy7, dqoe7, dqsoe7, dsr7, dsf7, dmr7, dmf7, dqr7, dqf7};

  localparam logic [VW-1:0] V_IDLE_RDY = {1'b1, 42'h0};

  int checks = 0, failures = 0;
  int edge_n = 0, pops = 0, pops3 = 0, pops7 = 0;
  logic [W-1:0]  fq[$];     // FIFO contents as seen by the DUT
  logic [W-1:0]  mq[$];     // model's view of words still available to the burst
  logic [VW-1:0] exp_q[$];  // expected observation per edge from acceptance on

  task automatic refresh();
    wfifo_empty = (fq.size() == 0);
    wfifo_dout  = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fq.push_back(w);
    refresh();
  endtask

  // one clock: pops seen before the edge are applied, then outputs are sampled at edge+1
  task automatic tick();
    logic p, p3, p7;
    @(negedge clk);
    p = wfifo_next; p3 = nxt3; p7 = nxt7;
    @(posedge clk);
    edge_n++;
    #1;
    if (p) begin
      pops++;
      if (fq.size() != 0) void'(fq.pop_front());
    end
    if (p3) pops3++;
    if (p7) pops7++;
    refresh();
  endtask

  // Burst timing from acceptance edge (j=0): preamble at j=wlat, four beats,
  // postamble at j=wlat+5 where ready is already back.
  task automatic model_burst(input int wlat);
    logic [W-1:0] w;
    for (int j = 0; j <= wlat + 5; j++) begin
      if (j == wlat) begin
        exp_q.push_back({3'b001, 40'h0});
      end else if (j > wlat && j <= wlat + 4) begin
        if (mq.size() != 0) begin
          w = mq.pop_front();
          exp_q.push_back({3'b011, 2'b11, 2'b00, w});
        end else begin
          exp_q.push_back({3'b011, 2'b11, 2'b00, 2'b11, 2'b11, 32'h0});
        end
      end else if (j == wlat + 5) begin
        exp_q.push_back({3'b101, 40'h0});
      end else begin
        exp_q.push_back('0);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (v_main !== V_IDLE_RDY) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", v_main, V_IDLE_RDY);
    end
    checks++;
    if (underrun !== 1'b0 || wfifo_next !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got underrun=%b next=%b exp 0 0", underrun, wfifo_next);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int p0;
    push_word(36'h0_AAAA_5555); push_word(36'h0_BBBB_4444);
    push_word(36'h0_CCCC_3333); push_word(36'h0_DDDD_2222);
    mq = fq; exp_q.delete(); model_burst(1);
    while (edge_n < 9) tick();
    p0 = pops;
    wr_start = 1'b1;
    for (int j = 0; j < exp_q.size(); j++) begin
      tick();
      wr_start = 1'b0;
      checks++;
      if (v_main !== exp_q[j]) begin
        failures++;
        $display("FAIL basic edge=%0d got=%h exp=%h", edge_n, v_main, exp_q[j]);
      end
    end
    checks++;
    if (pops - p0 !== 4) begin
      failures++;
      $display("FAIL basic_pops got=%0d exp=4", pops - p0);
    end
  endtask

  task automatic test_mask();
    push_word({4'b1001, 32'h1234_5678}); push_word(36'h0_0F0F_F0F0);
    push_word(36'hF_FFFF_0000);          push_word(36'h6_0000_FFFF);
    mq = fq; exp_q.delete(); model_burst(1);
    wr_start = 1'b1;
    for (int j = 0; j < exp_q.size(); j++) begin
      tick();
      wr_start = 1'b0;
      checks++;
      if (v_main !== exp_q[j]) begin
        failures++;
        $display("FAIL mask edge=%0d got=%h exp=%h", edge_n, v_main, exp_q[j]);
      end
      if (j == 2) begin
        checks++;
        if (ddr_dm_rise !== 2'b10 || ddr_dm_fall !== 2'b01) begin
          failures++;
          $display("FAIL mask_split got=%b/%b exp=10/01", ddr_dm_rise, ddr_dm_fall);
        end
      end
    end
  endtask

  task automatic test_random_bursts();
    int n, gap;
    logic exp_und;
    exp_und = underrun;
    for (int b = 0; b < 5; b++) begin
      n = $urandom_range(3, 5);
      for (int i = 0; i < n; i++) push_word({4'($urandom_range(0, 15)), 32'($urandom)});
      mq = fq;
      if (mq.size() < 4) exp_und = 1'b1;
      exp_q.delete(); model_burst(1);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        checks++;
        if (v_main !== V_IDLE_RDY) begin
          failures++;
          $display("FAIL rand_idle edge=%0d got=%h exp=%h", edge_n, v_main, V_IDLE_RDY);
        end
      end
      wr_start = 1'b1;
      for (int j = 0; j < exp_q.size(); j++) begin
        tick();
        wr_start = 1'b0;
        checks++;
        if (v_main !== exp_q[j]) begin
          failures++;
          $display("FAIL rand b=%0d edge=%0d got=%h exp=%h", b, edge_n, v_main, exp_q[j]);
        end
      end
      checks++;
      if (underrun !== exp_und) begin
        failures++;
        $display("FAIL rand_underrun b=%0d got=%b exp=%b", b, underrun, exp_und);
      end
    end
    fq.delete(); refresh();
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL rand_clear got=%b exp=0", underrun);
    end
  endtask

  task automatic test_underrun();
    int p0;
    push_word(36'h0_1111_EEEE); push_word(36'h0_2222_DDDD);
    mq = fq; exp_q.delete(); model_burst(1);
    p0 = pops;
    wr_start = 1'b1;
    for (int j = 0; j < exp_q.size(); j++) begin
      tick();
      wr_start = 1'b0;
      checks++;
      if (v_main !== exp_q[j]) begin
        failures++;
        $display("FAIL underrun_burst edge=%0d got=%h exp=%h", edge_n, v_main, exp_q[j]);
      end
    end
    checks++;
    if (pops - p0 !== 2) begin
      failures++;
      $display("FAIL underrun_pops got=%0d exp=2", pops - p0);
    end
    tick(); tick(); tick();
    checks++;
    if (underrun !== 1'b1) begin
      failures++;
      $display("FAIL underrun_sticky got=%b exp=1", underrun);
    end
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL underrun_clear got=%b exp=0", underrun);
    end
    // empty FIFO; clear lands on the same edge as the first starved beat
    mq.delete(); exp_q.delete(); model_burst(1);
    wr_start = 1'b1;
    for (int j = 0; j < exp_q.size(); j++) begin
      tick();
      wr_start = 1'b0;
      underrun_clr = (j + 1 == 2);
      checks++;
      if (v_main !== exp_q[j]) begin
        failures++;
        $display("FAIL underrun_empty edge=%0d got=%h exp=%h", edge_n, v_main, exp_q[j]);
      end
      if (j == 2) begin
        checks++;
        if (underrun !== 1'b1) begin
          failures++;
          $display("FAIL underrun_set_wins got=%b exp=1", underrun);
        end
      end
    end
    underrun_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    int p0;
    for (int i = 0; i < 8; i++) push_word({4'($urandom_range(0, 15)), 32'($urandom)});
    mq = fq; exp_q.delete(); model_burst(1); model_burst(1);
    p0 = pops;
    wr_start = 1'b1;
    for (int j = 0; j < exp_q.size(); j++) begin
      tick();
      if (j == 7) wr_start = 1'b0;
      checks++;
      if (v_main !== exp_q[j]) begin
        failures++;
        $display("FAIL b2b edge=%0d got=%h exp=%h", edge_n, v_main, exp_q[j]);
      end
    end
    tick();
    checks++;
    if (v_main !== V_IDLE_RDY) begin
      failures++;
      $display("FAIL b2b_no_third got=%h exp=%h", v_main, V_IDLE_RDY);
    end
    checks++;
    if (pops - p0 !== 8) begin
      failures++;
      $display("FAIL b2b_pops got=%0d exp=8", pops - p0);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    for (int i = 0; i < 4; i++) push_word({4'h0, 32'($urandom)});
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    tick(); tick();  // preamble, first beat
    reset = 1'b1;
    tick();          // second beat edge samples reset
    reset = 1'b0;
    checks++;
    if (v_main !== V_IDLE_RDY) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h exp=%h", v_main, V_IDLE_RDY);
    end
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_underrun got=%b exp=0", underrun);
    end
    p0 = pops;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (v_main !== V_IDLE_RDY) begin
        failures++;
        $display("FAIL reset_mid_idle edge=%0d got=%h exp=%h", edge_n, v_main, V_IDLE_RDY);
      end
    end
    checks++;
    if (pops !== p0) begin
      failures++;
      $display("FAIL reset_mid_pops got=%0d exp=%0d", pops, p0);
    end
    fq.delete(); refresh();
  endtask

  task automatic test_latency_sweep();
    logic [VW-1:0] e3[$], e7[$];
    int busy3, busy7, oe3, oe7;
    mq = {sw_dout, sw_dout, sw_dout, sw_dout}; exp_q.delete(); model_burst(3); e3 = exp_q;
    mq = {sw_dout, sw_dout, sw_dout, sw_dout}; exp_q.delete(); model_burst(7); e7 = exp_q;
    pops3 = 0; pops7 = 0; busy3 = 0; busy7 = 0; oe3 = 0; oe7 = 0;
    sw_start = 1'b1;
    for (int j = 0; j < e7.size() + 2; j++) begin
      tick();
      sw_start = 1'b0;
      busy3 += int'(!rdy3); busy7 += int'(!rdy7);
      oe3 += int'(dqoe3);   oe7 += int'(dqoe7);
      if (j < e3.size()) begin
        checks++;
        if (v3 !== e3[j]) begin
          failures++;
          $display("FAIL wlat3 j=%0d got=%h exp=%h", j, v3, e3[j]);
        end
      end
      checks++;
      if (v7 !== ((j < e7.size()) ? e7[j] : V_IDLE_RDY)) begin
        failures++;
        $display("FAIL wlat7 j=%0d got=%h", j, v7);
      end
    end
    checks++;
    if (busy3 !== 8 || busy7 !== 12) begin
      failures++;
      $display("FAIL sweep_busy got=%0d/%0d exp=8/12", busy3, busy7);
    end
    checks++;
    if (oe3 !== 4 || oe7 !== 4 || pops3 !== 4 || pops7 !== 4) begin
      failures++;
      $display("FAIL sweep_counts oe=%0d/%0d pops=%0d/%0d exp all 4", oe3, oe7, pops3, pops7);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    refresh();
    test_reset();
    test_basic();
    test_mask();
    test_random_bursts();
    test_underrun();
    test_back_to_back();
    test_reset_mid();
    test_latency_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
